// File: rtl/io_regs_pkg.sv
// Register map and widths shared by the peripheral register bus, the display
// controller and the software headers.
package io_regs_pkg;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = 12;
  localparam int NUM_BTN  = 4;
  localparam int NUM_COLL = 6;

  localparam logic [IDX_W-1:0] REG_BUTTONS   = 12'd0;
  localparam logic [IDX_W-1:0] REG_VBLANK    = 12'd1;
  localparam logic [IDX_W-1:0] REG_COLLISION = 12'd2;
  localparam logic [IDX_W-1:0] REG_PRESSES   = 12'd3;
  localparam logic [IDX_W-1:0] REG_FRAME     = 12'd4;
  localparam logic [IDX_W-1:0] REG_TIMER     = 12'd5;
endpackage

// File: rtl/io_register_controller_if.sv
// Core-side peripheral register bus: one-cycle read/write strobes, registered read data.
interface io_register_controller_if;
  import io_regs_pkg::*;
  logic [IDX_W-1:0]  register_index;
  logic              register_read;
  logic              register_write;
  logic [DATA_W-1:0] register_write_value;
  logic [DATA_W-1:0] register_read_value;

  modport master (
    output register_index, register_read, register_write, register_write_value,
    input  register_read_value
  );
  modport slave (
    input  register_index, register_read, register_write, register_write_value,
    output register_read_value
  );
endinterface

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer followed by a stable-count debouncer.
// rise_o pulses in the cycle whose edge takes state_o from 0 to 1.
module button_debouncer #(
  parameter  int DEBOUNCE_CYCLES = 250000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic state_o,
  output logic rise_o
);
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ, expire;

  assign differ = sync_q[1] ^ state_o;
  assign expire = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES-1));
  assign rise_o = expire & ~state_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (!differ) begin
        cnt_q <= '0;
      end else if (expire) begin
        state_o <= ~state_o;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/io_register_controller.sv
// Peripheral register block: debounced buttons, sticky clear-on-read event
// flags, frame counter and per-frame countdown timer behind a registered read mux.
module io_register_controller import io_regs_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                reset,
  io_register_controller_if.slave bus,
  input  logic [NUM_BTN-1:0]  buttons_i,
  input  logic                in_vblank_i,
  input  logic [NUM_COLL-1:0] collision_i
);
  logic [NUM_BTN-1:0]  debounced, btn_rise, press_q;
  logic [NUM_COLL-1:0] coll_q;
  logic [DATA_W-1:0]   frame_q, timer_q, rdata_q, rd_mux;
  logic                vb_prev_q, vb_flag_q, vb_rise;
  logic                rd, wr;
  logic [IDX_W-1:0]    idx;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (buttons_i[g]),
      .state_o (debounced[g]),
      .rise_o  (btn_rise[g])
    );
  end

  assign rd      = bus.register_read;
  assign wr      = bus.register_write;
  assign idx     = bus.register_index;
  assign vb_rise = in_vblank_i & ~vb_prev_q;
  assign bus.register_read_value = rdata_q;

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_BUTTONS:   rd_mux[NUM_BTN-1:0]  = debounced;
      REG_VBLANK:    rd_mux[1:0]          = {vb_flag_q, in_vblank_i};
      REG_COLLISION: rd_mux[NUM_COLL-1:0] = coll_q;
      REG_PRESSES:   rd_mux[NUM_BTN-1:0]  = press_q;
      REG_FRAME:     rd_mux               = frame_q;
      REG_TIMER:     rd_mux               = timer_q;
      default:       rd_mux               = '0;
    endcase
  end

  // Sticky flags: a new event in the clearing cycle survives (set wins), and
  // the read itself returns the pre-update value via rd_mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q   <= '0;
      vb_prev_q <= 1'b0;
      vb_flag_q <= 1'b0;
      coll_q    <= '0;
      press_q   <= '0;
      frame_q   <= '0;
      timer_q   <= '0;
    end else begin
      vb_prev_q <= in_vblank_i;
      if (rd) rdata_q <= rd_mux;

      vb_flag_q <= vb_rise     | (vb_flag_q & ~(rd && idx == REG_VBLANK));
      coll_q    <= collision_i | ((rd && idx == REG_COLLISION) ? '0 : coll_q);
      press_q   <= btn_rise    | ((rd && idx == REG_PRESSES)   ? '0 : press_q);

      if (wr && idx == REG_FRAME)  frame_q <= bus.register_write_value;
      else if (vb_rise)            frame_q <= frame_q + DATA_W'(1);

      if (wr && idx == REG_TIMER)        timer_q <= bus.register_write_value;
      else if (vb_rise && timer_q != '0) timer_q <= timer_q - DATA_W'(1);
    end
  end
endmodule

// File: tb/tb_io_register_controller.sv
// Directed scenarios plus random traffic, every read checked against a
// cycle-stepped behavioural model of the register block.
module tb_io_register_controller;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       vblank;
  logic [5:0] coll;

  io_register_controller_if bus();

  io_register_controller #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .buttons_i   (btn),
    .in_vblank_i (vblank),
    .collision_i (coll)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // Model state: button i is accepted once its synchronized sample has
  // disagreed with the accepted value for N consecutive edges.
  logic [3:0]  m_s1, m_s2, m_deb, m_press;
  int          m_streak [4];
  logic        m_vbprev, m_vbflag;
  logic [5:0]  m_coll;
  logic [15:0] m_frame, m_timer, m_rdata;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_press = '0;
    for (int b = 0; b < 4; b++) m_streak[b] = 0;
    m_vbprev = 1'b0; m_vbflag = 1'b0; m_coll = '0;
    m_frame = '0; m_timer = '0; m_rdata = '0;
  endtask

  task automatic model_step();
    logic       rise, rd, wr;
    logic [3:0] newrise;
    int         idx;
    rd   = bus.register_read;
    wr   = bus.register_write;
    idx  = int'(bus.register_index);
    rise = vblank && !m_vbprev;
    if (rd) begin
      if      (idx == 0) m_rdata = {12'd0, m_deb};
      else if (idx == 1) m_rdata = {14'd0, m_vbflag, vblank};
      else if (idx == 2) m_rdata = {10'd0, m_coll};
      else if (idx == 3) m_rdata = {12'd0, m_press};
      else if (idx == 4) m_rdata = m_frame;
      else if (idx == 5) m_rdata = m_timer;
      else               m_rdata = 16'd0;
    end
    newrise = '0;
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_deb[b]) begin
        m_streak[b]++;
        if (m_streak[b] == N) begin
          m_deb[b] = ~m_deb[b];
          m_streak[b] = 0;
          newrise[b] = m_deb[b];
        end
      end else m_streak[b] = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
    m_press  = newrise | ((rd && idx == 3) ? 4'd0 : m_press);
    m_vbflag = rise || (m_vbflag && !(rd && idx == 1));
    m_coll   = coll | ((rd && idx == 2) ? 6'd0 : m_coll);
    if (wr && idx == 4)  m_frame = bus.register_write_value;
    else if (rise)       m_frame = m_frame + 16'd1;
    if (wr && idx == 5)              m_timer = bus.register_write_value;
    else if (rise && m_timer != 0)   m_timer = m_timer - 16'd1;
    m_vbprev = vblank;
  endtask

  // One clock: drive strobes, step model at the edge, check any read at the falling edge.
  task automatic cyc(input logic rd, input logic wr, input logic [11:0] idx, input logic [15:0] wd);
    bus.register_read = rd;
    bus.register_write = wr;
    bus.register_index = idx;
    bus.register_write_value = wd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (rd) chk($sformatf("model_rd idx%0d", idx), bus.register_read_value, m_rdata);
    bus.register_read = 1'b0;
    bus.register_write = 1'b0;
  endtask

  task automatic rd_c(input logic [11:0] idx, input logic [15:0] exp, input string tag);
    cyc(1'b1, 1'b0, idx, 16'd0);
    chk(tag, bus.register_read_value, exp);
  endtask

  task automatic vb_edge();
    vblank = 1'b1; cyc(1'b0, 1'b0, 12'd0, 16'd0);
    vblank = 1'b0; cyc(1'b0, 1'b0, 12'd0, 16'd0);
  endtask

  logic [15:0] tim_exp [4] = '{16'd1, 16'd0, 16'd0, 16'd0};

  initial begin
    int lat;
    logic [15:0] first;
    reset = 1'b1; btn = '0; vblank = 1'b0; coll = '0;
    bus.register_read = 1'b0; bus.register_write = 1'b0;
    bus.register_index = '0; bus.register_write_value = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rdata", bus.register_read_value, 16'd0);
    reset = 1'b0;
    rd_c(12'd4, 16'd0, "reset_frame");

    // Debounced level is set by edge 2+N after the change; the registered read sees it one read later.
    btn = 4'b0001; lat = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 1'b0, 12'd0, 16'd0);
      if (lat == 0 && bus.register_read_value[0]) lat = k;
    end
    chk("btn_latency", 16'(lat), 16'(2 + N + 1));
    rd_c(12'd0, 16'h0001, "btn0_level");
    rd_c(12'd3, 16'h0001, "press0");
    rd_c(12'd3, 16'h0000, "press0_cleared");

    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) btn[1] = ~btn[1];
      cyc(1'b0, 1'b0, 12'd0, 16'd0);
    end
    btn[1] = 1'b0;
    rd_c(12'd0, 16'h0001, "bounce_level");
    rd_c(12'd3, 16'h0000, "bounce_press");

    coll = 6'b100010; cyc(1'b0, 1'b0, 12'd0, 16'd0);
    coll = 6'b000000;
    rd_c(12'd2, 16'h0022, "coll_sticky");
    rd_c(12'd2, 16'h0000, "coll_cleared");
    coll = 6'b100000; cyc(1'b0, 1'b0, 12'd0, 16'd0);
    coll = 6'b000001;
    rd_c(12'd2, 16'h0020, "coll_read_old");
    coll = 6'b000000;
    rd_c(12'd2, 16'h0001, "coll_set_wins");

    cyc(1'b0, 1'b1, 12'd4, 16'hFFFE);
    repeat (3) vb_edge();
    rd_c(12'd4, 16'h0001, "frame_wrap");
    vblank = 1'b1; cyc(1'b0, 1'b1, 12'd4, 16'h1234);
    vblank = 1'b0; cyc(1'b0, 1'b0, 12'd0, 16'd0);
    rd_c(12'd4, 16'h1234, "frame_write_wins");

    cyc(1'b0, 1'b1, 12'd5, 16'd2);
    for (int i = 0; i < 4; i++) begin
      vb_edge();
      rd_c(12'd5, tim_exp[i], $sformatf("timer_%0d", i));
    end
    rd_c(12'd1, 16'h0002, "vbflag_set");
    rd_c(12'd1, 16'h0000, "vbflag_cleared");
    cyc(1'b1, 1'b1, 12'd5, 16'h0007);
    chk("rdwr_pre_value", bus.register_read_value, 16'h0000);
    rd_c(12'd5, 16'h0007, "rdwr_write_done");
    cyc(1'b0, 1'b1, 12'd0, 16'hFFFF);
    rd_c(12'd0, 16'h0001, "ro_write_ignored");

    // Reset mid-debounce and mid-frame, asserted between clock edges.
    cyc(1'b0, 1'b1, 12'd4, 16'h00AA);
    btn = 4'b0101;
    cyc(1'b0, 1'b0, 12'd0, 16'd0);
    rd_c(12'd4, 16'h00AA, "frame_loaded");
    #2 reset = 1'b1;
    #1 chk("async_reset", bus.register_read_value, 16'h0000);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    lat = 0; first = 16'hFFFF;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 1'b0, 12'd0, 16'd0);
      if (k == 1) first = bus.register_read_value;
      if (lat == 0 && bus.register_read_value != 0) lat = k;
    end
    chk("post_reset_btn", first, 16'h0000);
    chk("post_reset_latency", 16'(lat), 16'(2 + N + 1));
    rd_c(12'd0, 16'h0005, "post_reset_level");
    rd_c(12'd4, 16'h0000, "post_reset_frame");

    for (int k = 0; k < 800; k++) begin
      logic [11:0] idx;
      if ($urandom_range(0, 15) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) vblank = ~vblank;
      coll = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      idx = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 6));
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, idx, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
